// File: rtl/spi_reg_publisher.sv
// Scans NCH sensor words and publishes each changed (or forced) word into the
// SPI slave register bank. One channel slot per cycle; all outputs registered.
module spi_reg_publisher #(
  parameter int unsigned NCH            = 3,
  parameter int unsigned DW             = 32,
  parameter logic [31:0] BASE_ADDR      = 32'd0,
  parameter int unsigned REFRESH_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [NCH-1:0]    ch_enable,
  input  logic              force_all,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [NCH-1:0]    pending
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0] dirty_q, dirty_d;
  logic [DW-1:0]  shadow_q [NCH];
  logic           mem_we_q;
  logic [31:0]    mem_addr_q;
  logic [DW-1:0]  mem_wdata_q;

  logic [DW-1:0]  sel_data, sel_shadow;
  logic           sel_en, sel_dirty;
  logic           wr;
  logic           refresh_tc;

  generate
    if (REFRESH_CYCLES > 0) begin : g_refresh
      localparam int unsigned RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
      localparam logic [RW-1:0] RTC = RW'(REFRESH_CYCLES - 1);
      logic [RW-1:0] refresh_q;

      assign refresh_tc = (refresh_q == RTC);

      always_ff @(posedge clk) begin
        if (reset) begin
          refresh_q <= '0;
        end else if (refresh_tc) begin
          refresh_q <= '0;
        end else begin
          refresh_q <= refresh_q + 1'b1;
        end
      end
    end else begin : g_no_refresh
      assign refresh_tc = 1'b0;
    end
  endgenerate

  // Mux out the channel under the scan pointer.
  always_comb begin
    sel_data   = '0;
    sel_shadow = '0;
    sel_en     = 1'b0;
    sel_dirty  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ptr_q == PW'(i)) begin
        sel_data   = ch_data[i*DW +: DW];
        sel_shadow = shadow_q[i];
        sel_en     = ch_enable[i];
        sel_dirty  = dirty_q[i];
      end
    end
  end

  assign wr = sel_en && ((sel_data != sel_shadow) || sel_dirty);

  // A dirty set in the same cycle as the write of that channel wins.
  always_comb begin
    dirty_d = dirty_q;
    for (int i = 0; i < NCH; i++) begin
      if (wr && (ptr_q == PW'(i))) begin
        dirty_d[i] = 1'b0;
      end
    end
    if (force_all || refresh_tc) begin
      dirty_d = dirty_d | ch_enable;
    end
  end

  assign ptr_d = (ptr_q == PW'(NCH - 1)) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      dirty_q     <= '1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      dirty_q  <= dirty_d;
      mem_we_q <= wr;
      if (wr) begin
        mem_addr_q  <= BASE_ADDR + 32'(ptr_q);
        mem_wdata_q <= sel_data;
        for (int i = 0; i < NCH; i++) begin
          if (ptr_q == PW'(i)) begin
            shadow_q[i] <= sel_data;
          end
        end
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pending   = dirty_q;

endmodule

// File: tb/tb_spi_reg_publisher.sv
// Directed bench for spi_reg_publisher: three instances cover the default
// 3-channel setup, periodic refresh, and a 16-channel offset-address bank.
module tb_spi_reg_publisher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // instance A: NCH=3, BASE=0, no refresh
  logic         reset_a;
  logic [95:0]  ch_data_a;
  logic [2:0]   en_a;
  logic         force_a;
  logic         we_a;
  logic [31:0]  addr_a;
  logic [31:0]  wdata_a;
  logic [2:0]   pend_a;

  // instance B: NCH=3, BASE=0, refresh every 10 cycles
  logic         reset_b;
  logic [95:0]  ch_data_b;
  logic [2:0]   en_b;
  logic         force_b;
  logic         we_b;
  logic [31:0]  addr_b;
  logic [31:0]  wdata_b;
  logic [2:0]   pend_b;

  // instance C: NCH=16, BASE=2, no refresh
  logic         reset_c;
  logic [511:0] ch_data_c;
  logic [15:0]  en_c;
  logic         force_c;
  logic         we_c;
  logic [31:0]  addr_c;
  logic [31:0]  wdata_c;
  logic [15:0]  pend_c;

  spi_reg_publisher #(.NCH(3), .DW(32), .BASE_ADDR(32'd0), .REFRESH_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset_a), .ch_data(ch_data_a), .ch_enable(en_a),
    .force_all(force_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .pending(pend_a)
  );

  spi_reg_publisher #(.NCH(3), .DW(32), .BASE_ADDR(32'd0), .REFRESH_CYCLES(10)) dut_b (
    .clk(clk), .reset(reset_b), .ch_data(ch_data_b), .ch_enable(en_b),
    .force_all(force_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .pending(pend_b)
  );

  spi_reg_publisher #(.NCH(16), .DW(32), .BASE_ADDR(32'd2), .REFRESH_CYCLES(0)) dut_c (
    .clk(clk), .reset(reset_c), .ch_data(ch_data_c), .ch_enable(en_c),
    .force_all(force_c), .mem_we(we_c), .mem_addr(addr_c), .mem_wdata(wdata_c),
    .pending(pend_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          cnt_a [3];
  logic [31:0] last_a [3];
  int          cnt_a_bad;

  task automatic clr_a();
    for (int i = 0; i < 3; i++) begin
      cnt_a[i]  = 0;
      last_a[i] = '0;
    end
    cnt_a_bad = 0;
  endtask

  task automatic run_a(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      if (we_a) begin
        if (addr_a < 32'd3) begin
          cnt_a[addr_a]++;
          last_a[addr_a] = wdata_a;
        end else begin
          cnt_a_bad++;
        end
      end
    end
  endtask

  int cnt_b [3];
  int bad_b;
  logic found;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    force_a = 1'b0; force_b = 1'b0; force_c = 1'b0;
    ch_data_a = {32'd3, 32'd2, 32'd1};
    en_a = 3'b111;
    ch_data_b = {32'd30, 32'd20, 32'd10};
    en_b = 3'b111;
    for (int i = 0; i < 16; i++) ch_data_c[i*32 +: 32] = 32'h100 + 32'(i);
    en_c = 16'hFFFF;
    tick();
    tick();

    // 1: reset state and post-reset publish
    check("rst_we",    64'(we_a), 64'd0);
    check("rst_addr",  64'(addr_a), 64'd0);
    check("rst_wdata", 64'(wdata_a), 64'd0);
    check("rst_pend",  64'(pend_a), 64'h7);
    reset_a = 1'b0;
    tick();
    check("pub0_we", 64'(we_a), 64'd1);
    check("pub0_addr", 64'(addr_a), 64'd0);
    check("pub0_data", 64'(wdata_a), 64'd1);
    tick();
    check("pub1_we", 64'(we_a), 64'd1);
    check("pub1_addr", 64'(addr_a), 64'd1);
    check("pub1_data", 64'(wdata_a), 64'd2);
    tick();
    check("pub2_we", 64'(we_a), 64'd1);
    check("pub2_addr", 64'(addr_a), 64'd2);
    check("pub2_data", 64'(wdata_a), 64'd3);
    check("pub2_pend", 64'(pend_a), 64'd0);
    tick();
    check("pub_idle_we", 64'(we_a), 64'd0);
    clr_a();
    run_a(25);
    check("static_no_wr", 64'(cnt_a[0] + cnt_a[1] + cnt_a[2] + cnt_a_bad), 64'd0);

    // 2: single change on ch1
    ch_data_a[63:32] = 32'h0000ABCD;
    clr_a();
    run_a(4);
    check("chg_cnt1", 64'(cnt_a[1]), 64'd1);
    check("chg_data1", 64'(last_a[1]), 64'h0000ABCD);
    check("chg_others", 64'(cnt_a[0] + cnt_a[2] + cnt_a_bad), 64'd0);

    // 3: enable mask
    en_a = 3'b101;
    ch_data_a[63:32] = 32'd7;
    clr_a();
    run_a(6);
    check("mask_cnt1", 64'(cnt_a[1]), 64'd0);
    check("mask_total", 64'(cnt_a[0] + cnt_a[2] + cnt_a_bad), 64'd0);
    en_a = 3'b111;
    clr_a();
    run_a(4);
    check("unmask_cnt1", 64'(cnt_a[1]), 64'd1);
    check("unmask_data1", 64'(last_a[1]), 64'd7);

    // 4: force_all in the same cycle as a ch0 write
    ch_data_a[31:0] = 32'h55;
    found = 1'b0;
    for (int k = 0; k < 5 && !found; k++) begin
      tick();
      if (we_a && addr_a == 32'd0) found = 1'b1;
    end
    check("sync_ch0_found", 64'(found), 64'd1);
    ch_data_a[31:0] = 32'h66;
    tick();
    check("sync_gap1_we", 64'(we_a), 64'd0);
    tick();
    check("sync_gap2_we", 64'(we_a), 64'd0);
    force_a = 1'b1;
    tick();
    force_a = 1'b0;
    check("frc_we", 64'(we_a), 64'd1);
    check("frc_addr", 64'(addr_a), 64'd0);
    check("frc_data", 64'(wdata_a), 64'h66);
    check("frc_pend", 64'(pend_a), 64'h7);
    tick();
    check("frc_s1_addr", 64'({we_a, addr_a}), {31'd0, 1'b1, 32'd1});
    check("frc_s1_data", 64'(wdata_a), 64'd7);
    check("frc_s1_pend", 64'(pend_a), 64'h5);
    tick();
    check("frc_s2_addr", 64'({we_a, addr_a}), {31'd0, 1'b1, 32'd2});
    check("frc_s2_data", 64'(wdata_a), 64'd3);
    check("frc_s2_pend", 64'(pend_a), 64'h1);
    tick();
    check("frc_s3_addr", 64'({we_a, addr_a}), {31'd0, 1'b1, 32'd0});
    check("frc_s3_data", 64'(wdata_a), 64'h66);
    check("frc_s3_pend", 64'(pend_a), 64'h0);
    tick();
    check("frc_idle_we", 64'(we_a), 64'd0);

    // 5: periodic refresh, static data
    reset_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ref_pub%0d", k), 64'({we_b, addr_b, wdata_b[7:0]}),
            64'({1'b1, 32'(k), 8'(10 * (k + 1))}));
    end
    for (int i = 0; i < 3; i++) cnt_b[i] = 0;
    bad_b = 0;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (j == 6) check("ref_pend_e10", 64'(pend_b), 64'h7);
      if (we_b) begin
        if (addr_b < 32'd3) begin
          cnt_b[addr_b]++;
          if (wdata_b != 32'(10 * (addr_b + 1))) bad_b++;
        end else begin
          bad_b++;
        end
      end
    end
    for (int i = 0; i < 3; i++) check($sformatf("ref_cnt%0d", i), 64'(cnt_b[i]), 64'd3);
    check("ref_bad", 64'(bad_b), 64'd0);

    // 6: 16 channels, base 2, reset mid-publish, pointer wrap
    reset_c = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("c_pre%0d", k), 64'({we_c, addr_c}), {31'd0, 1'b1, 32'(k + 1)});
    end
    reset_c = 1'b1;
    tick();
    check("c_rst_we", 64'(we_c), 64'd0);
    check("c_rst_addr", 64'(addr_c), 64'd2);
    check("c_rst_pend", 64'(pend_c), 64'hFFFF);
    reset_c = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("c_pub%0d", k), 64'({we_c, addr_c}), {31'd0, 1'b1, 32'(k + 1)});
      check($sformatf("c_dat%0d", k), 64'(wdata_c), 64'(32'h100 + 32'(k - 1)));
      if (k == 1) ch_data_c[31:0] = 32'hC0DE;
    end
    tick();
    check("c_wrap_addr", 64'({we_c, addr_c}), {31'd0, 1'b1, 32'd2});
    check("c_wrap_data", 64'(wdata_c), 64'hC0DE);
    tick();
    check("c_idle_we", 64'(we_c), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
